// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: sequences memory cycles and round-robin shares the memory port between CPU and DMA.
//
// Ports:
//   i_clock, i_reset_n                          clock, asynchronous active-low reset
//   i_cpu_req/i_cpu_wr/i_cpu_addr/i_cpu_wdata   CPU request (level, held until ack)
//   o_cpu_ack                                   one-cycle CPU completion pulse
//   i_dma_req/i_dma_wr/i_dma_addr/i_dma_wdata   DMA request (level, held until ack)
//   o_dma_ack                                   one-cycle DMA completion pulse
//   o_rd_data                                   read data captured for the DONE cycle, shared
//   o_mem_addr/o_mem_wdata                      registered address / write data to memories
//   i_mem_rdata                                 read data from memories
//   o_mem_rd/o_mem_wr                           read / write strobes
//   o_rom_cs/o_ram_cs                           chip selects (ROM = reads of 0xF000-0xFFFF)
//   o_busy                                      high whenever not IDLE
//
// Build option: define ROM_WAIT_EN to give ROM reads ROM_WAIT wait cycles;
// otherwise ROM reads use RAM_WAIT and ROM_WAIT is ignored.
module mem_access_arbiter #(
    parameter int RAM_WAIT = 1,
    parameter int ROM_WAIT = 2
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_cpu_req,
    input  logic        i_cpu_wr,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    input  logic        i_dma_req,
    input  logic        i_dma_wr,
    input  logic [15:0] i_dma_addr,
    input  logic [7:0]  i_dma_wdata,
    output logic        o_dma_ack,
    output logic [7:0]  o_rd_data,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_rom_cs,
    output logic        o_ram_cs,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [2:0] RAM_W = 3'(RAM_WAIT);
`ifdef ROM_WAIT_EN
    localparam logic [2:0] ROM_W = 3'(ROM_WAIT);
`else
    // ROM shares the RAM timing; the zero term only keeps ROM_WAIT referenced.
    localparam logic [2:0] ROM_W = 3'(RAM_WAIT + 0 * ROM_WAIT);
`endif

    state_t      r_state, w_next;
    logic        r_gnt_dma, r_last_dma, r_wr;
    logic [2:0]  r_cnt;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata, r_rd_data;
    logic        w_start, w_pick_dma, w_rom, w_cs;

    assign w_start = i_cpu_req || i_dma_req;
    // On a tie the requester that was not served last wins.
    assign w_pick_dma = i_dma_req && (!i_cpu_req || !r_last_dma);
    assign w_rom = (r_mem_addr[15:12] == 4'hF) && !r_wr;

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rd_data   = r_rd_data;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_cs      = 1'b0;
        o_mem_rd  = 1'b0;
        o_mem_wr  = 1'b0;
        o_cpu_ack = 1'b0;
        o_dma_ack = 1'b0;
        case (r_state)
            IDLE:    w_next = w_start ? SETUP : IDLE;
            SETUP: begin
                w_cs     = 1'b1;
                o_mem_rd = !r_wr;
                w_next   = ACCESS;
            end
            ACCESS: begin
                w_cs     = 1'b1;
                o_mem_rd = !r_wr;
                o_mem_wr = r_wr;
                w_next   = (r_cnt == 3'd0) ? DONE : ACCESS;
            end
            DONE: begin
                o_cpu_ack = !r_gnt_dma;
                o_dma_ack = r_gnt_dma;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
        o_rom_cs = w_cs && w_rom;
        o_ram_cs = w_cs && !w_rom;
        o_busy   = (r_state != IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_gnt_dma   <= 1'b0;
            r_last_dma  <= 1'b1;
            r_wr        <= 1'b0;
            r_cnt       <= 3'd0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 8'h00;
            r_rd_data   <= 8'h00;
        end else begin
            // Request is latched on entry to SETUP so address and decode are valid during SETUP.
            if (r_state == IDLE && w_start) begin
                r_gnt_dma   <= w_pick_dma;
                r_wr        <= w_pick_dma ? i_dma_wr : i_cpu_wr;
                r_mem_addr  <= w_pick_dma ? i_dma_addr : i_cpu_addr;
                r_mem_wdata <= w_pick_dma ? i_dma_wdata : i_cpu_wdata;
            end
            if (r_state == SETUP)
                r_cnt <= w_rom ? ROM_W : RAM_W;
            if (r_state == ACCESS && r_cnt != 3'd0)
                r_cnt <= r_cnt - 3'd1;
            // Sampled on the last ACCESS edge so the data is already valid during DONE.
            if (r_state == ACCESS && r_cnt == 3'd0 && !r_wr)
                r_rd_data <= i_mem_rdata;
            if (r_state == DONE)
                r_last_dma <= r_gnt_dma;
        end
    end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: randomized self-checking bench for mem_access_arbiter against a transaction-level model.
module tb_mem_access_arbiter;
    localparam int RAMW = 1;
`ifdef ROM_WAIT_EN
    localparam int ROMW = 2;
`else
    localparam int ROMW = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_wr, dma_req, dma_wr;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic        cpu_ack, dma_ack, mem_rd, mem_wr, rom_cs, ram_cs, busy;
    logic [7:0]  rd_data, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    logic [7:0]  dev_ram [0:65535];
    logic [7:0]  ref_ram [0:65535];
    bit          m_last_dma;
    logic [7:0]  exp_rd;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    mem_access_arbiter #(.RAM_WAIT(1), .ROM_WAIT(2)) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_ack(cpu_ack),
        .i_dma_req(dma_req), .i_dma_wr(dma_wr), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .o_dma_ack(dma_ack),
        .o_rd_data(rd_data), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_rom_cs(rom_cs), .o_ram_cs(ram_cs), .o_busy(busy)
    );

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        return a[7:0] + 8'h3E;
    endfunction

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 7 + 3);
    endfunction

    // Memory devices seen by the DUT.
    always_comb mem_rdata = rom_cs ? rom_byte(mem_addr) : dev_ram[mem_addr];
    always @(posedge clk) if (mem_wr && ram_cs) dev_ram[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Grant rule: a lone requester wins; on a tie the one not served last wins.
    function automatic bit predict(input bit c, input bit d);
        if (c && d) return !m_last_dma;
        return d;
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [3:0] hi;
        hi = ($urandom_range(0, 2) == 0) ? 4'hF : 4'h1;
        return {hi, 9'h000, 3'($urandom_range(0, 7))};
    endfunction

    task automatic drop(input bit g);
        if (g) dma_req = 1'b0; else cpu_req = 1'b0;
    endtask

    // Called at the negedge of cycle 0 with requests already driven.
    task automatic run_access(input bit g, input int drop_c, input bit keep);
        logic        wr, cs, rom;
        logic [15:0] a;
        logic [7:0]  d;
        logic [6:0]  exp_v;
        int          w;
        wr  = g ? dma_wr : cpu_wr;
        a   = g ? dma_addr : cpu_addr;
        d   = g ? dma_wdata : cpu_wdata;
        rom = (a >= 16'hF000) && !wr;
        w   = rom ? ROMW : RAMW;
        for (int c = 1; c <= 3 + w; c++) begin
            @(posedge clk);
            @(negedge clk);
            cs = (c <= 2 + w);
            exp_v = {rom && cs, !rom && cs, cs && !wr, cs && wr && c >= 2,
                     c == 3 + w && !g, c == 3 + w && g, 1'b1};
            check($sformatf("strobes c%0d", c), 32'({rom_cs, ram_cs, mem_rd, mem_wr, cpu_ack, dma_ack, busy}), 32'(exp_v));
            if (c == 1) begin
                check("mem_addr", 32'(mem_addr), 32'(a));
                if (wr) check("mem_wdata", 32'(mem_wdata), 32'(d));
            end
            if (c == 3 + w) begin
                if (wr) ref_ram[a] = d;
                else exp_rd = rom ? rom_byte(a) : ref_ram[a];
                check("rd_data", 32'(rd_data), 32'(exp_rd));
                m_last_dma = g;
                if (!keep) drop(g);
            end
            if (c == drop_c) drop(g);
        end
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        #1;
        check("rst_strobes", 32'({rom_cs, ram_cs, mem_rd, mem_wr, cpu_ack, dma_ack, busy}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'({rd_data, mem_wdata}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_ack", 32'({cpu_ack, dma_ack}), 32'd0);
        end
        rst_n      = 1'b1;
        m_last_dma = 1'b1;
        exp_rd     = 8'h00;
    endtask

    task automatic set_cpu(input logic w, input logic [15:0] a, input logic [7:0] d);
        cpu_wr = w; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    endtask

    task automatic set_dma(input logic w, input logic [15:0] a, input logic [7:0] d);
        dma_wr = w; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            dev_ram[i] = init_byte(i);
            ref_ram[i] = init_byte(i);
        end
        {cpu_wr, dma_wr, cpu_addr, dma_addr, cpu_wdata, dma_wdata} = '0;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        rst_n   = 1'b1;
        #2;
        do_reset();

        set_cpu(1'b1, 16'h1234, 8'hA5);
        run_access(1'b0, 0, 1'b0);
        set_cpu(1'b0, 16'hF000, 8'h00);
        run_access(1'b0, 0, 1'b0);
        set_cpu(1'b1, 16'hF010, 8'h77);
        run_access(1'b0, 0, 1'b0);
        set_cpu(1'b0, 16'h1234, 8'h00);
        run_access(1'b0, 2, 1'b0);

        set_cpu(1'b1, 16'h2000, 8'h11);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_wr", 32'(mem_wr), 32'd1);
        do_reset();

        set_cpu(1'b0, 16'h1234, 8'h00);
        set_dma(1'b1, 16'h1300, 8'h5C);
        run_access(predict(1'b1, 1'b1), 0, 1'b1);
        run_access(predict(1'b1, 1'b1), 0, 1'b1);
        run_access(predict(1'b1, 1'b1), 0, 1'b0);
        run_access(predict(cpu_req, dma_req), 0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int mode;
            mode = $urandom_range(0, 2);
            if (mode != 1) set_cpu(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            if (mode != 0) set_dma(1'($urandom_range(0, 1)), rand_addr(), 8'($urandom));
            run_access(predict(cpu_req, dma_req), 0, 1'b0);
            if (cpu_req || dma_req) run_access(predict(cpu_req, dma_req), 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
